// File: rtl/multicycle_ctrl_fsm_if.sv
// Control/status bundle between the multicycle control FSM (master) and the datapath (slave).
interface multicycle_ctrl_fsm_if #(
   parameter int unsigned INST_SIZE = 32,
   parameter int unsigned CNT_WIDTH = 32
);
   // Datapath -> control
   logic [INST_SIZE-1:0] instr;
   logic                 comparison;
   logic                 imem_ready;
   logic                 dmem_ready;
   // Control -> datapath
   logic                 imem_req;
   logic                 ir_wr;
   logic                 pc_wr;
   logic [1:0]           if_mux_sel;
   logic                 ex_mux_sel;
   logic [1:0]           wb_mux_sel;
   logic                 reg_file_rd;
   logic                 reg_file_wr;
   logic                 mem_read;
   logic                 mem_write;
   logic                 one_byte;
   logic                 two_bytes;
   logic                 four_bytes;
   logic                 halted;
   logic [1:0]           err_code;
   logic [CNT_WIDTH-1:0] instret;

   modport master (
      input  instr, comparison, imem_ready, dmem_ready,
      output imem_req, ir_wr, pc_wr, if_mux_sel, ex_mux_sel, wb_mux_sel,
      output reg_file_rd, reg_file_wr, mem_read, mem_write,
      output one_byte, two_bytes, four_bytes, halted, err_code, instret
   );

   modport slave (
      output instr, comparison, imem_ready, dmem_ready,
      input  imem_req, ir_wr, pc_wr, if_mux_sel, ex_mux_sel, wb_mux_sel,
      input  reg_file_rd, reg_file_wr, mem_read, mem_write,
      input  one_byte, two_bytes, four_bytes, halted, err_code, instret
   );
endinterface

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle RV32I control path: FETCH/DECODE/EXEC/MEM/WB sequencing with memory ready
// handshakes, wait timeout, sticky trap and retired-instruction counter.
module multicycle_ctrl_fsm #(
   parameter int unsigned INST_SIZE   = 32,
   parameter int unsigned MEM_TIMEOUT = 16,
   parameter int unsigned CNT_WIDTH   = 32
) (
   input logic                   clk,
   input logic                   rst,
   multicycle_ctrl_fsm_if.master bus
);

   localparam int unsigned WaitW = $clog2(MEM_TIMEOUT + 1);
   localparam logic [WaitW-1:0] WaitLast = WaitW'(MEM_TIMEOUT - 1);

   localparam logic [6:0] OpR     = 7'b0110011;
   localparam logic [6:0] OpImm   = 7'b0010011;
   localparam logic [6:0] OpLoad  = 7'b0000011;
   localparam logic [6:0] OpStore = 7'b0100011;
   localparam logic [6:0] OpBr    = 7'b1100011;
   localparam logic [6:0] OpJal   = 7'b1101111;
   localparam logic [6:0] OpJalr  = 7'b1100111;
   localparam logic [6:0] OpLui   = 7'b0110111;
   localparam logic [6:0] OpAuipc = 7'b0010111;

   typedef enum logic [2:0] {
      StFetch,
      StDecode,
      StExec,
      StMem,
      StWb,
      StTrap
   } state_e;

   state_e               state_q, state_d;
   logic [WaitW-1:0]     wait_q, wait_d;
   logic [1:0]           err_q, err_d;
   logic [CNT_WIDTH-1:0] instret_q, instret_d;
   logic                 retire;

   logic       imem_req_raw, ir_wr_raw, pc_wr_raw, ex_sel_raw;
   logic       rd_raw, wr_raw, mem_read_raw, mem_write_raw;
   logic       one_raw, two_raw, four_raw;
   logic [1:0] if_sel_raw, wb_sel_raw;

   // Instruction field decode; only opcode and funct3 steer the control path.
   logic [6:0] opcode;
   logic [1:0] size;
   logic       is_r, is_br, is_load, is_store, is_jal, is_jalr, is_auipc, is_legal;
   logic       unused_instr_bits;

   assign opcode   = bus.instr[6:0];
   assign size     = bus.instr[13:12];
   assign is_r     = (opcode == OpR);
   assign is_br    = (opcode == OpBr);
   assign is_load  = (opcode == OpLoad);
   assign is_store = (opcode == OpStore);
   assign is_jal   = (opcode == OpJal);
   assign is_jalr  = (opcode == OpJalr);
   assign is_auipc = (opcode == OpAuipc);
   assign is_legal = is_r || is_br || is_load || is_store || is_jal || is_jalr || is_auipc ||
                     (opcode == OpImm) || (opcode == OpLui);
   assign unused_instr_bits = ^{bus.instr[INST_SIZE-1:15], bus.instr[14], bus.instr[11:7]};

   // State, wait counter, error code and retire counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StFetch;
         wait_q    <= '0;
         err_q     <= 2'd0;
         instret_q <= '0;
      end else begin
         state_q   <= state_d;
         wait_q    <= wait_d;
         err_q     <= err_d;
         instret_q <= instret_d;
      end
   end

   // Next-state and raw control decode from current state and instruction.
   always_comb begin
      state_d       = state_q;
      wait_d        = wait_q;
      err_d         = err_q;
      retire        = 1'b0;
      imem_req_raw  = 1'b0;
      ir_wr_raw     = 1'b0;
      pc_wr_raw     = 1'b0;
      if_sel_raw    = 2'd0;
      ex_sel_raw    = 1'b0;
      wb_sel_raw    = 2'd0;
      rd_raw        = 1'b0;
      wr_raw        = 1'b0;
      mem_read_raw  = 1'b0;
      mem_write_raw = 1'b0;
      one_raw       = 1'b0;
      two_raw       = 1'b0;
      four_raw      = 1'b0;

      unique case (state_q)
         StFetch: begin
            imem_req_raw = 1'b1;
            if (bus.imem_ready) begin
               ir_wr_raw = 1'b1;
               state_d   = StDecode;
            end else if (wait_q == WaitLast) begin
               state_d = StTrap;
               err_d   = 2'd2;
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end
         StDecode: begin
            rd_raw = 1'b1;
            if (!is_legal || ((is_load || is_store) && size == 2'b11)) begin
               state_d = StTrap;
               err_d   = 2'd1;
            end else begin
               state_d = StExec;
            end
         end
         StExec: begin
            ex_sel_raw = !(is_r || is_br);
            if (is_br) begin
               pc_wr_raw  = 1'b1;
               if_sel_raw = bus.comparison ? 2'd1 : 2'd0;
               retire     = 1'b1;
               state_d    = StFetch;
            end else if (is_load || is_store) begin
               state_d = StMem;
            end else begin
               state_d = StWb;
            end
         end
         StMem: begin
            mem_read_raw  = is_load;
            mem_write_raw = is_store;
            one_raw       = (size == 2'b00);
            two_raw       = (size == 2'b01);
            four_raw      = (size == 2'b10);
            if (bus.dmem_ready) begin
               if (is_store) begin
                  pc_wr_raw = 1'b1;
                  retire    = 1'b1;
                  state_d   = StFetch;
               end else begin
                  state_d = StWb;
               end
            end else if (wait_q == WaitLast) begin
               state_d = StTrap;
               err_d   = 2'd3;
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end
         StWb: begin
            wr_raw    = 1'b1;
            pc_wr_raw = 1'b1;
            if (is_load) begin
               wb_sel_raw = 2'd1;
            end else if (is_jal || is_jalr) begin
               wb_sel_raw = 2'd2;
            end else if (is_auipc) begin
               wb_sel_raw = 2'd3;
            end
            if (is_jal) begin
               if_sel_raw = 2'd1;
            end else if (is_jalr) begin
               if_sel_raw = 2'd2;
            end
            retire  = 1'b1;
            state_d = StFetch;
         end
         StTrap: begin
            state_d = StTrap;
         end
         default: begin
            state_d = StFetch;
         end
      endcase

      if (state_d != state_q) begin
         wait_d = '0;
      end
      instret_d = retire ? instret_q + 1'b1 : instret_q;
   end

   // Outputs are forced low while reset is high so an aborted access never commits.
   assign bus.imem_req    = imem_req_raw & ~rst;
   assign bus.ir_wr       = ir_wr_raw & ~rst;
   assign bus.pc_wr       = pc_wr_raw & ~rst;
   assign bus.if_mux_sel  = rst ? 2'd0 : if_sel_raw;
   assign bus.ex_mux_sel  = ex_sel_raw & ~rst;
   assign bus.wb_mux_sel  = rst ? 2'd0 : wb_sel_raw;
   assign bus.reg_file_rd = rd_raw & ~rst;
   assign bus.reg_file_wr = wr_raw & ~rst;
   assign bus.mem_read    = mem_read_raw & ~rst;
   assign bus.mem_write   = mem_write_raw & ~rst;
   assign bus.one_byte    = one_raw & ~rst;
   assign bus.two_bytes   = two_raw & ~rst;
   assign bus.four_bytes  = four_raw & ~rst;
   assign bus.halted      = (state_q == StTrap) & ~rst;
   assign bus.err_code    = rst ? 2'd0 : err_q;
   assign bus.instret     = rst ? '0 : instret_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed bench for multicycle_ctrl_fsm with a per-instruction schedule model.
module tb_multicycle_ctrl_fsm;

   localparam int unsigned TO = 16;
   localparam int unsigned CW = 4;

   typedef enum int {KR, KI, KLd, KSt, KBr, KJal, KJalr, KLui, KAuipc, KBad} kind_e;

   typedef struct packed {
      logic          imem_req;
      logic          ir_wr;
      logic          pc_wr;
      logic [1:0]    if_sel;
      logic          ex_sel;
      logic [1:0]    wb_sel;
      logic          rd;
      logic          wr;
      logic          mrd;
      logic          mwr;
      logic          b1;
      logic          b2;
      logic          b4;
      logic          halted;
      logic [1:0]    err;
      logic [CW-1:0] instret;
   } obs_t;

   logic clk;
   logic rst;
   int   vectors;
   int   miscompares;
   int   exp_instret;
   int   mrd_seen;
   int   cyc;

   multicycle_ctrl_fsm_if #(.INST_SIZE(32), .CNT_WIDTH(CW)) bus ();

   multicycle_ctrl_fsm #(
      .INST_SIZE  (32),
      .MEM_TIMEOUT(TO),
      .CNT_WIDTH  (CW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic kind_e kind_of(input logic [31:0] ins);
      case (ins[6:0])
         7'b0110011: return KR;
         7'b0010011: return KI;
         7'b0000011: return KLd;
         7'b0100011: return KSt;
         7'b1100011: return KBr;
         7'b1101111: return KJal;
         7'b1100111: return KJalr;
         7'b0110111: return KLui;
         7'b0010111: return KAuipc;
         default:    return KBad;
      endcase
   endfunction

   function automatic obs_t idle();
      obs_t r;
      r = '0;
      r.instret = CW'(exp_instret);
      return r;
   endfunction

   function automatic obs_t sample();
      obs_t a;
      a.imem_req = bus.imem_req;
      a.ir_wr    = bus.ir_wr;
      a.pc_wr    = bus.pc_wr;
      a.if_sel   = bus.if_mux_sel;
      a.ex_sel   = bus.ex_mux_sel;
      a.wb_sel   = bus.wb_mux_sel;
      a.rd       = bus.reg_file_rd;
      a.wr       = bus.reg_file_wr;
      a.mrd      = bus.mem_read;
      a.mwr      = bus.mem_write;
      a.b1       = bus.one_byte;
      a.b2       = bus.two_bytes;
      a.b4       = bus.four_bytes;
      a.halted   = bus.halted;
      a.err      = bus.err_code;
      a.instret  = bus.instret;
      return a;
   endfunction

   task automatic chk(input string name, input int got, input int want);
      vectors++;
      if (got != want) begin
         miscompares++;
         $display("FAIL %s: got %0d want %0d", name, got, want);
      end
   endtask

   // Drive one cycle of inputs, compare all outputs mid-cycle, return just after next edge.
   task automatic apply(input logic [31:0] ins, input logic cmp, input logic ir, input logic dr,
                        input obs_t e, input string tag);
      obs_t a;
      bus.instr      = ins;
      bus.comparison = cmp;
      bus.imem_ready = ir;
      bus.dmem_ready = dr;
      @(negedge clk);
      a = sample();
      if (a.mrd) mrd_seen++;
      vectors++;
      if (a !== e) begin
         miscompares++;
         $display("FAIL %s @%0t: got %h want %h", tag, $time, a, e);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic retire();
      exp_instret = (exp_instret + 1) % (1 << CW);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      exp_instret = 0;
      apply(32'h0, 1'b0, 1'b1, 1'b1, obs_t'('0), "in_reset");
      apply(32'h0, 1'b0, 1'b1, 1'b1, obs_t'('0), "in_reset");
      rst = 1'b0;
   endtask

   task automatic trap_cycles(input logic [31:0] ins, input logic [1:0] err);
      obs_t r;
      for (int i = 0; i < 3; i++) begin
         r = idle();
         r.halted = 1'b1;
         r.err = err;
         apply(ins, 1'b1, 1'b1, 1'b1, r, "trap");
      end
   endtask

   // Walk one instruction through the phases it must visit; other ready is held high to
   // show readies are ignored outside their own wait state.
   task automatic run_instr(input logic [31:0] ins, input logic cmp, input int fwait,
                            input int mwait, output int n);
      obs_t       r;
      kind_e      k;
      logic [1:0] sz;
      k  = kind_of(ins);
      sz = ins[13:12];
      n  = 0;
      for (int i = 0; i < fwait && i < TO; i++) begin
         r = idle();
         r.imem_req = 1'b1;
         apply(ins, cmp, 1'b0, 1'b1, r, "fetch_wait");
         n++;
      end
      if (fwait >= TO) begin
         trap_cycles(ins, 2'd2);
         return;
      end
      r = idle();
      r.imem_req = 1'b1;
      r.ir_wr = 1'b1;
      apply(ins, cmp, 1'b1, 1'b1, r, "fetch");
      n++;
      r = idle();
      r.rd = 1'b1;
      apply(ins, cmp, 1'b1, 1'b1, r, "decode");
      n++;
      if (k == KBad || ((k == KLd || k == KSt) && sz == 2'b11)) begin
         trap_cycles(ins, 2'd1);
         return;
      end
      r = idle();
      r.ex_sel = !(k == KR || k == KBr);
      if (k == KBr) begin
         r.pc_wr = 1'b1;
         r.if_sel = cmp ? 2'd1 : 2'd0;
         apply(ins, cmp, 1'b1, 1'b1, r, "exec_branch");
         n++;
         retire();
         return;
      end
      apply(ins, cmp, 1'b1, 1'b1, r, "exec");
      n++;
      if (k == KLd || k == KSt) begin
         r = idle();
         r.mrd = (k == KLd);
         r.mwr = (k == KSt);
         r.b1 = (sz == 2'd0);
         r.b2 = (sz == 2'd1);
         r.b4 = (sz == 2'd2);
         for (int i = 0; i < mwait && i < TO; i++) begin
            apply(ins, cmp, 1'b1, 1'b0, r, "mem_wait");
            n++;
         end
         if (mwait >= TO) begin
            trap_cycles(ins, 2'd3);
            return;
         end
         if (k == KSt) begin
            r.pc_wr = 1'b1;
            apply(ins, cmp, 1'b1, 1'b1, r, "mem_store");
            n++;
            retire();
            return;
         end
         apply(ins, cmp, 1'b1, 1'b1, r, "mem_load");
         n++;
      end
      r = idle();
      r.wr = 1'b1;
      r.pc_wr = 1'b1;
      if (k == KLd) r.wb_sel = 2'd1;
      else if (k == KJal || k == KJalr) r.wb_sel = 2'd2;
      else if (k == KAuipc) r.wb_sel = 2'd3;
      if (k == KJal) r.if_sel = 2'd1;
      else if (k == KJalr) r.if_sel = 2'd2;
      apply(ins, cmp, 1'b1, 1'b1, r, "wb");
      n++;
      retire();
   endtask

   // Store whose MEM cycle is cut short by an asynchronous reset.
   task automatic store_abort(input logic [31:0] ins);
      obs_t r;
      r = idle();
      r.imem_req = 1'b1;
      r.ir_wr = 1'b1;
      apply(ins, 1'b0, 1'b1, 1'b1, r, "abort_fetch");
      r = idle();
      r.rd = 1'b1;
      apply(ins, 1'b0, 1'b1, 1'b1, r, "abort_decode");
      r = idle();
      r.ex_sel = 1'b1;
      apply(ins, 1'b0, 1'b1, 1'b1, r, "abort_exec");
      bus.dmem_ready = 1'b0;
      #1;
      chk("abort_mem_write_before", int'(bus.mem_write), 1);
      rst = 1'b1;
      #1;
      chk("abort_mem_write_after", int'(bus.mem_write), 0);
      chk("abort_pc_wr_after", int'(bus.pc_wr), 0);
      exp_instret = 0;
      apply(ins, 1'b0, 1'b1, 1'b0, obs_t'('0), "abort_reset");
      apply(ins, 1'b0, 1'b1, 1'b0, obs_t'('0), "abort_reset");
      rst = 1'b0;
      chk("abort_instret", int'(bus.instret), 0);
   endtask

   initial begin
      int m0;
      vectors        = 0;
      miscompares    = 0;
      exp_instret    = 0;
      mrd_seen       = 0;
      rst            = 1'b1;
      bus.instr      = 32'h0;
      bus.comparison = 1'b0;
      bus.imem_ready = 1'b0;
      bus.dmem_ready = 1'b0;

      do_reset();
      chk("reset_instret", int'(bus.instret), 0);
      chk("reset_halted", int'(bus.halted), 0);

      run_instr(32'h00500093, 1'b1, 0, 0, cyc);               // ADDI x1,x0,5
      chk("addi_latency", cyc, 4);
      chk("addi_instret", int'(bus.instret), 1);

      m0 = mrd_seen;
      run_instr(32'h0000A103, 1'b0, 0, 3, cyc);               // LW, dmem stalls 3
      chk("lw_latency", cyc, 8);
      chk("lw_mem_read_cycles", mrd_seen - m0, 4);
      chk("lw_instret", int'(bus.instret), 2);

      run_instr(32'h00000463, 1'b1, 0, 0, cyc);               // BEQ taken
      chk("beq_latency", cyc, 3);
      run_instr(32'h00000463, 1'b0, 0, 0, cyc);               // BEQ not taken
      run_instr(32'h000100E7, 1'b0, 0, 0, cyc);               // JALR
      run_instr(32'h00110023, 1'b1, 0, 0, cyc);               // SB
      chk("sb_latency", cyc, 4);
      run_instr(32'h00009103, 1'b0, 2, 1, cyc);               // LH
      run_instr(32'h00112023, 1'b0, 1, 2, cyc);               // SW
      run_instr(32'h002081B3, 1'b1, 0, 0, cyc);               // ADD
      run_instr(32'h010000EF, 1'b0, 0, 0, cyc);               // JAL
      run_instr(32'h123452B7, 1'b0, 0, 0, cyc);               // LUI
      run_instr(32'h00001317, 1'b0, 0, 0, cyc);               // AUIPC
      run_instr(32'h00500093, 1'b0, TO - 1, 0, cyc);          // ready on last fetch cycle
      run_instr(32'h0000A103, 1'b0, 0, TO - 1, cyc);          // ready on last mem cycle
      run_instr(32'h00500093, 1'b0, 0, 0, cyc);
      run_instr(32'h00500093, 1'b0, 0, 0, cyc);
      chk("instret_wrap", int'(bus.instret), 0);
      run_instr(32'h00500093, 1'b0, 0, 0, cyc);
      chk("instret_after_wrap", int'(bus.instret), 1);

      store_abort(32'h00110023);
      run_instr(32'h00500093, 1'b0, 0, 0, cyc);
      chk("post_abort_instret", int'(bus.instret), 1);

      run_instr(32'h0000007F, 1'b0, 0, 0, cyc);               // illegal opcode
      chk("illegal_err", int'(bus.err_code), 1);
      chk("illegal_halted", int'(bus.halted), 1);
      do_reset();

      run_instr(32'h0000B103, 1'b0, 0, 0, cyc);               // load funct3=011
      chk("bad_size_err", int'(bus.err_code), 1);
      do_reset();

      run_instr(32'h00500093, 1'b0, TO, 0, cyc);              // imem never ready
      chk("imem_timeout_fetch_cycles", cyc, 16);
      chk("imem_timeout_err", int'(bus.err_code), 2);
      chk("imem_timeout_halted", int'(bus.halted), 1);
      do_reset();
      chk("reset_clears_err", int'(bus.err_code), 0);

      run_instr(32'h00112023, 1'b0, 0, TO, cyc);              // dmem never ready
      chk("dmem_timeout_err", int'(bus.err_code), 3);
      do_reset();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
